// File: rtl/serial_add_sub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_ctrl_pkg
// Brief    : Shared types and constants for the nibble-serial add/sub sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_sub_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sub_ctrl_add_sub_4b.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_4b
// Brief    : 4-bit adder stage; Y is XORed with Cin internally before the add.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_4b
    import serial_add_sub_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, y ^ {NIBBLE_W{cin}}} + {{NIBBLE_W{1'b0}}, cin};
        s   = sum[NIBBLE_W-1:0];
        co  = sum[NIBBLE_W];
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_ctrl
// Brief    : NIBBLES x 4-bit add/sub sequenced LSB nibble first through one stage.
//            Define SERIAL_ADDSUB_FLAGS_EN to add the zero/ovf result flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub_ctrl
    import serial_add_sub_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          sub,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   result,
    output logic                          cout
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ,
    output logic                          zero,
    output logic                          ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = clog2(NIBBLES);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                c_q, c_d;
    logic                sub_q, sub_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        result_q, result_d;
    logic                cout_q, cout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] stage_a;
    logic [NIBBLE_W-1:0] stage_y;
    logic [NIBBLE_W-1:0] stage_s;
    logic                stage_co;

    // The extra ^c cancels the stage's internal Cin XOR, leaving b ^ sub as effective B.
    always_comb begin
        stage_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        stage_y = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}} ^ {NIBBLE_W{c_q}};
    end

    add_sub_4b u_stage (
        .a   (stage_a),
        .y   (stage_y),
        .cin (c_q),
        .s   (stage_s),
        .co  (stage_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        c_d      = c_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            ST_RUN: begin
                result_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = stage_s;
                c_d = stage_co;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = ST_DONE;
                    cout_d  = stage_co;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                    zero_d  = (result_d == '0);
                    ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (stage_s[NIBBLE_W-1] != a_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    idx_d   = '0;
                    c_d     = sub;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            c_q      <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    assign zero   = zero_q;
    assign ovf    = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub_ctrl
// Brief    : Self-checking bench for serial_add_sub_ctrl (NIBBLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub_ctrl;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic        zero;
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_add_sub_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_FLAGS_EN
        ,
        .zero   (zero),
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, result} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [15:0] sa16, sb16;
        int ua, ub, sa, sb, r, sr;
        logic c, ov;
        logic [15:0] r16;
        ua = int'(a);
        ub = int'(b);
        sa16 = a;
        sb16 = b;
        sa = sa16;
        sb = sb16;
        if (s) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            c  = (r > 65535);
            sr = sa + sb;
        end
        ov  = (sr > 32767) || (sr < -32768);
        r16 = r[15:0];
        return {ov, c, r16};
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after a bound).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        start = 1'b1;
        sub   = s;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        sub   = 1'($urandom);
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef SERIAL_ADDSUB_FLAGS_EN
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_directed;
        logic [15:0] ta [7] = '{16'h1234, 16'h1000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h5A5A};
        logic [15:0] tb [7] = '{16'h0FCD, 16'h0001, 16'h0002, 16'h0001, 16'h0001, 16'h0001, 16'h5A5A};
        logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] er [7] = '{16'h2201, 16'h0FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000};
        logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        ez [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], lat);
            checks++; if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
            checks++; if (result !== er[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, result, er[i]); end
            checks++; if (cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout: got %b want %b", i, cout, ec[i]); end
`ifdef SERIAL_ADDSUB_FLAGS_EN
            checks++; if (zero !== ez[i]) begin errors++; $display("FAIL dir%0d_zero: got %b want %b", i, zero, ez[i]); end
            checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b want %b", i, ovf, eo[i]); end
`else
            if (ez[i] === 1'bx || eo[i] === 1'bx) errors++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        start = 1'b1; sub = 1'b0; op_a = 16'h1111; op_b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; sub = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
        @(negedge clk);
        op_a = 16'h0F0F; op_b = 16'hF0F0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy4: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", done); end
        checks++; if (result !== 16'h3333) begin errors++; $display("FAIL ign_result: got %h want 3333", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ign_cout: got %b want 0", cout); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_after: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(16'hABCD, 16'h1234, 1'b0, lat);
        checks++; if (result !== 16'hBE01) begin errors++; $display("FAIL b2b_first: got %h want be01", result); end
        run_op(16'h0100, 16'h0200, 1'b1, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
        checks++; if (result !== 16'hFF00) begin errors++; $display("FAIL b2b_result: got %h want ff00", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_cout: got %b want 0", cout); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start = 1'b1; sub = 1'b0; op_a = 16'h1111; op_b = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstrun_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (result !== 16'h0 || cout !== 1'b0) begin errors++; $display("FAIL rstrun_data: got %h/%b want 0000/0", result, cout); end
`ifdef SERIAL_ADDSUB_FLAGS_EN
        checks++; if (zero !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rstrun_flags: got %b%b want 00", zero, ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_idle: got busy=%b want 0", busy); end
        run_op(16'h4321, 16'h1234, 1'b1, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL rstrun_latency: got %0d want %0d", lat, LAT); end
        checks++; if (result !== 16'h30ED || cout !== 1'b1) begin errors++; $display("FAIL rstrun_result: got %h/%b want 30ed/1", result, cout); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [15:0] edges [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] a, b;
        logic        s;
        logic [17:0] exp;
        int lat;
        for (int n = 0; n < 10000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = edges[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) b = edges[$urandom_range(0, 3)];
            exp = model(a, b, s);
            run_op(a, b, s, lat);
            checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency: got %0d want %0d", lat, LAT); end
            checks++; if (result !== exp[15:0]) begin errors++; $display("FAIL rnd_result: %h %s %h got %h want %h", a, s ? "-" : "+", b, result, exp[15:0]); end
            checks++; if (cout !== exp[16]) begin errors++; $display("FAIL rnd_cout: %h %s %h got %b want %b", a, s ? "-" : "+", b, cout, exp[16]); end
`ifdef SERIAL_ADDSUB_FLAGS_EN
            checks++; if (ovf !== exp[17]) begin errors++; $display("FAIL rnd_ovf: %h %s %h got %b want %b", a, s ? "-" : "+", b, ovf, exp[17]); end
            checks++; if (zero !== (exp[15:0] == 16'h0)) begin errors++; $display("FAIL rnd_zero: got %b want %b", zero, exp[15:0] == 16'h0); end
`endif
            if (errors > 50) break;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serial_add_sub_ctrl.md
# serial_add_sub_ctrl

Multi-cycle sequencer that performs NIBBLES×4-bit add/subtract by time-multiplexing one 4-bit adder/subtractor stage, one nibble per clock, least significant nibble first. It sits directly upstream and downstream of the 4-bit stage. It latches wide operands and drives nibble operands plus the carry/mode line into the stage. It then captures each nibble sum and the carry-out, and presents the wide result through a start/done handshake.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4×NIBBLES; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only in IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- op_a  in  W  operand A; sampled with start.
- op_b  in  W  operand B; sampled with start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when result/cout are final.
- result  out  W  sum/difference (mod 2^W).
- cout  out  1  final carry; for subtraction, 1 = no borrow (A ≥ B unsigned).
- zero  out  1  result == 0 (SERIAL_ADDSUB_FLAGS_EN only).
- ovf  out  1  signed two's-complement overflow (SERIAL_ADDSUB_FLAGS_EN only).

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN: lasts exactly NIBBLES cycles.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after the nibble index reaches NIBBLES−1.
  - DONE→RUN if start is high, else DONE→IDLE.
- On accept: latch op_a, op_b and sub. Clear the nibble index. Set the carry register c = sub.
- Per RUN cycle i, the stage inputs are:
  - A = op_a[4i+3:4i]
  - Y = op_b[4i+3:4i] ^ {4{sub}} ^ {4{c}}
  - Cin = c
- The stage XORs Y with Cin internally, so its effective B is op_b nibble ^ {4{sub}}. This gives true ripple carry and borrow chaining across nibbles.
- Capture the stage sum into result[4i+3:4i] and its carry into c. Increment i.
- cout is the final c. ovf is the XOR of the carry into and out of the top nibble's MSB. ovf is computed from operand/result sign bits: (a_msb == b_eff_msb) && (r_msb != a_msb).
- start while busy is ignored; the latched operands stay unchanged.
- Input changes during RUN have no effect.
- result, cout and flags hold their last value until the next accept. They are not cleared on accept. Partial nibbles update during RUN and are valid only when done = 1.
- Reset at any time, including mid-RUN, forces the IDLE state. All outputs reset to 0: busy, done, result, cout, zero, ovf.

## Timing
- start high in cycle 0 (accepted) gives busy = 1 in cycles 1..NIBBLES and done = 1 in cycle NIBBLES+1. Latency is NIBBLES+1 cycles.
- A start in the done cycle is accepted. Back-to-back throughput is one operation per NIBBLES+1 cycles.
- All outputs are registered. The stage path is combinational within one cycle.

## Configuration
- SERIAL_ADDSUB_FLAGS_EN defined: the zero and ovf ports exist. Both are registered, update in the done cycle and reset to 0.
- Not defined: zero, ovf and their logic are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state enum: IDLE, RUN, DONE.
  - NIBBLE_W = 4 constant.
  - Nibble-index width function clog2(NIBBLES).
- One sub-module: instantiate add_sub_4b as the nibble datapath. No other hierarchy.

## Test plan (NIBBLES = 4)
- Add 0x1234 + 0x0FCD → done at cycle 5, result 0x2201, cout 0, zero 0, ovf 0.
- Sub 0x1000 − 0x0001 → result 0x0FFF, cout 1; sub 0x0001 − 0x0002 → result 0xFFFF, cout 0 (borrow).
- Add 0xFFFF + 0x0001 → result 0x0000, cout 1, zero 1, ovf 0; add 0x7FFF + 0x0001 → 0x8000, ovf 1; sub 0x8000 − 0x0001 → 0x7FFF, ovf 1.
- Pulse start with new operands in cycles 2 and 3 of an operation → ignored; the original result is returned. Start in the done cycle → the second op completes 5 cycles later.
- Deassert rst_n during RUN cycle 2 → busy, done, result, cout and flags read 0 immediately. The FSM returns to IDLE, and the next start completes normally.
- Random sweep of 10k operations against a W-bit reference model for result, cout and ovf.
